// File: rtl/cn_msg_gen_if.sv
// Handshake bundle between the CNU, the message generator and the VNU path.
// slave is the generator's view; master is the view of whatever drives it.
interface cn_msg_gen_if #(
  parameter int BITS        = 8,
  parameter int dmax        = 10,
  parameter int INPUTS_BITS = $clog2(dmax)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [BITS-1:0]        min1;
  logic [BITS-1:0]        min2;
  logic [INPUTS_BITS-1:0] idx_min;
  logic [dmax-1:0]        sign_bits;
  logic [INPUTS_BITS:0]   deg;
  logic                   out_valid;
  logic                   out_ready;
  logic [BITS-1:0]        out_msg;
  logic [INPUTS_BITS-1:0] out_edge;
  logic                   out_last;

  modport slave (
    input  in_valid, min1, min2, idx_min,
    input  sign_bits, deg, out_ready,
    output in_ready, out_valid, out_msg,
    output out_edge, out_last
  );

  modport master (
    output in_valid, min1, min2, idx_min,
    output sign_bits, deg, out_ready,
    input  in_ready, out_valid, out_msg,
    input  out_edge, out_last
  );
endinterface

// File: rtl/cn_msg_gen.sv
// Check-to-variable message generator: expands a compressed CNU record
// into one offset-min-sum message per edge, one edge per cycle.
module cn_msg_gen #(
  parameter int BITS        = 8,
  parameter int dmax        = 10,
  parameter int INPUTS_BITS = $clog2(dmax),
  parameter int OFFSET      = 1,
  parameter int DEPTH       = 2
) (
  input logic        clk,
  input logic        rst,
  cn_msg_gen_if.slave bus
);
  localparam int MAX = 2**(BITS-1)-1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH+1);
  localparam int DW  = INPUTS_BITS+1;

  localparam logic [DW-1:0] DEG_MAX = DW'(dmax);
  localparam logic [DW-1:0] DEG_ONE = DW'(1);

  typedef struct packed {
    logic [BITS-1:0]        min1;
    logic [BITS-1:0]        min2;
    logic [INPUTS_BITS-1:0] idx;
    logic [dmax-1:0]        sign;
    logic [DW-1:0]          deg;
  } rec_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                 state;
  rec_t                   mem [DEPTH];
  rec_t                   wrk;
  rec_t                   inrec;
  logic [PW-1:0]          wp;
  logic [PW-1:0]          rp;
  logic [CW-1:0]          count;
  logic [INPUTS_BITS-1:0] ecnt;

  logic push;
  logic pop;
  logic nonempty;
  logic last;
  logic emit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign nonempty    = (count != '0);
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push        = bus.in_valid && bus.in_ready;
  assign last        = ({1'b0, ecnt} == wrk.deg - DEG_ONE);
  assign emit        = (state == EMIT);
  assign pop         = nonempty &&
                       (!emit || (bus.out_ready && last));

  always_comb begin
    inrec      = '0;
    inrec.min1 = bus.min1;
    inrec.min2 = bus.min2;
    inrec.idx  = bus.idx_min;
    inrec.sign = bus.sign_bits;
    inrec.deg  = bus.deg;
    if (bus.deg == '0 || bus.deg > DEG_MAX)
      inrec.deg = DEG_MAX;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= inrec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wrk   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ecnt  <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop) begin
        wrk  <= mem[rp];
        rp   <= nxt(rp);
        ecnt <= '0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      unique case (state)
        IDLE: if (nonempty) state <= EMIT;
        EMIT: begin
          if (bus.out_ready) begin
            if (!last)
              ecnt <= ecnt + INPUTS_BITS'(1);
            else if (!nonempty)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                   tsign;
  logic                   sb;
  logic                   sgn;
  logic [BITS-1:0]        mag;
  logic signed [BITS:0]   diff;
  logic [BITS-1:0]        magc;
  logic [BITS-1:0]        msg;

  // Only edges below deg contribute to the row parity.
  always_comb begin
    tsign = 1'b0;
    sb    = 1'b0;
    for (int j = 0; j < dmax; j++) begin
      if (j < int'(wrk.deg)) tsign = tsign ^ wrk.sign[j];
      if (j == int'(ecnt))   sb    = wrk.sign[j];
    end
    sgn  = tsign ^ sb;
    mag  = (ecnt == wrk.idx) ? wrk.min2 : wrk.min1;
    diff = $signed({mag[BITS-1], mag}) - $signed((BITS+1)'(OFFSET));
    if (diff < 0)
      magc = '0;
    else if (diff > $signed((BITS+1)'(MAX)))
      magc = BITS'(MAX);
    else
      magc = diff[BITS-1:0];
    msg = sgn ? -magc : magc;
  end

  assign bus.out_valid = emit;
  assign bus.out_msg   = emit ? msg : '0;
  assign bus.out_edge  = emit ? ecnt : '0;
  assign bus.out_last  = emit && last;
endmodule

// File: tb/tb_cn_msg_gen.sv
// Directed bench for cn_msg_gen: latency, arithmetic, clipping,
// backpressure, back-to-back records and asynchronous reset.
module tb_cn_msg_gen;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct {
    logic [7:0] msg;
    logic [3:0] e;
    logic       last;
  } beat_t;

  beat_t q[$];

  cn_msg_gen_if #(.BITS(8), .dmax(10)) bus ();

  cn_msg_gen #(
    .BITS(8), .dmax(10), .OFFSET(1), .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      q.push_back('{bus.out_msg, bus.out_edge, bus.out_last});
  end

  task automatic push_rec(input int d, input int m1, input int m2,
                          input int ix, input logic [9:0] sb);
    bit ok;
    ok = 0;
    bus.deg       = 5'(d);
    bus.min1      = 8'(m1);
    bus.min2      = 8'(m2);
    bus.idx_min   = 4'(ix);
    bus.sign_bits = sb;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.in_ready === 1'b1) ok = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL push_timeout got=no_accept exp=accept");
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    checks++;
    if ({bus.out_valid, bus.out_msg, bus.out_edge, bus.out_last}
        !== 14'd0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0",
               {bus.out_valid, bus.out_msg, bus.out_edge, bus.out_last});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_single;
    int em[4] = '{-4, -4, 8, 4};
    bus.out_ready = 1'b1;
    push_rec(4, 5, 9, 2, 10'b0000000011);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got=%b exp=0", bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_msg !== 8'(em[i]) ||
          bus.out_edge !== 4'(i) || bus.out_last !== (i == 3)) begin
        failures++;
        $display("FAIL single_beat%0d got=v%b m%0d e%0d l%b exp=v1 m%0d e%0d l%b",
                 i, bus.out_valid, $signed(bus.out_msg), bus.out_edge,
                 bus.out_last, em[i], i, (i == 3));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_end got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_offset_clip;
    q.delete();
    push_rec(3, 0, 1, 0, 10'h3FF);
    wait_cycles(8);
    checks++;
    if (q.size() != 3) begin
      failures++;
      $display("FAIL clip_count got=%0d exp=3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q[i].msg !== 8'd0 || q[i].last !== (i == 2)) begin
          failures++;
          $display("FAIL clip_beat%0d got=m%h l%b exp=m00 l%b",
                   i, q[i].msg, q[i].last, (i == 2));
        end
      end
    end
  endtask

  task automatic test_idx_range;
    int em[3] = '{6, -6, -6};
    int ex;
    q.delete();
    push_rec(3, 7, 20, 5, 10'b1111111001);
    wait_cycles(8);
    checks++;
    if (q.size() != 3) begin
      failures++;
      $display("FAIL idx_count got=%0d exp=3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q[i].msg !== 8'(em[i])) begin
          failures++;
          $display("FAIL idx_beat%0d got=%0d exp=%0d",
                   i, $signed(q[i].msg), em[i]);
        end
      end
    end
    q.delete();
    push_rec(0, 3, 50, 9, 10'b0000000001);
    wait_cycles(15);
    checks++;
    if (q.size() != 10) begin
      failures++;
      $display("FAIL deg0_count got=%0d exp=10", q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        ex = (i == 0) ? 2 : (i == 9) ? -49 : -2;
        checks++;
        if (q[i].msg !== 8'(ex) || q[i].e !== 4'(i) ||
            q[i].last !== (i == 9)) begin
          failures++;
          $display("FAIL deg0_beat%0d got=m%0d e%0d l%b exp=m%0d e%0d l%b",
                   i, $signed(q[i].msg), q[i].e, q[i].last, ex, i, (i == 9));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int em[6] = '{19, 9, -2, 3, 126, -126};
    q.delete();
    bus.out_ready = 1'b0;
    push_rec(2, 10, 20, 0, 10'b00);
    push_rec(2, 3, 4, 1, 10'b10);
    push_rec(2, 127, 127, 0, 10'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_msg !== 8'd19 || bus.out_edge !== 4'd0) begin
        failures++;
        $display("FAIL stall%0d got=r%b v%b m%0d e%0d exp=r0 v1 m19 e0",
                 i, bus.in_ready, bus.out_valid,
                 $signed(bus.out_msg), bus.out_edge);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold got=%b exp=0", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL first_pop got=%b exp=1", bus.in_ready);
    end
    wait_cycles(8);
    checks++;
    if (q.size() != 6) begin
      failures++;
      $display("FAIL drain_count got=%0d exp=6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (q[i].msg !== 8'(em[i]) || q[i].e !== 4'(i % 2) ||
            q[i].last !== (i % 2 == 1)) begin
          failures++;
          $display("FAIL drain_beat%0d got=m%0d e%0d l%b exp=m%0d e%0d l%b",
                   i, $signed(q[i].msg), q[i].e, q[i].last,
                   em[i], i % 2, (i % 2 == 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int em[4] = '{3, 5, -7, -1};
    bus.out_ready = 1'b1;
    push_rec(2, 4, 6, 1, 10'b00);
    push_rec(2, 2, 8, 0, 10'b11);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_msg !== 8'(em[i]) ||
          bus.out_last !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL b2b_beat%0d got=v%b m%0d l%b exp=v1 m%0d l%b",
                 i, bus.out_valid, $signed(bus.out_msg), bus.out_last,
                 em[i], (i % 2 == 1));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got=%b exp=0", bus.out_valid);
    end
    push_rec(2, 4, 6, 1, 10'b00);
    push_rec(2, 2, 8, 0, 10'b11);
    wait_cycles(2);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_msg !== 8'(-7)) begin
      failures++;
      $display("FAIL b2b_beat3 got=v%b m%0d exp=v1 m-7",
               bus.out_valid, $signed(bus.out_msg));
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_msg, bus.out_edge, bus.out_last}
        !== 14'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_rst got=%h r%b exp=0 r1",
               {bus.out_valid, bus.out_msg, bus.out_edge, bus.out_last},
               bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    wait_cycles(6);
    checks++;
    if (q.size() != 0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_rst got=n%0d v%b exp=n0 v0",
               q.size(), bus.out_valid);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.min1      = '0;
    bus.min2      = '0;
    bus.idx_min   = '0;
    bus.sign_bits = '0;
    bus.deg       = '0;
    test_reset();
    test_single();
    test_offset_clip();
    test_idx_range();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cn_msg_gen.md
Name: cn_msg_gen

Overview:
- Check-to-variable message generator: consumes the compressed check-node result produced by the CNU min-finder (min1, min2, idx_min) plus per-edge sign bits.
- Expands each result into one signed offset-min-sum message per row edge, serialized one edge per cycle.
- Sits between the CNU and the VNU/LLR update path; a 2-entry record FIFO decouples the two sides with valid/ready on both.

Parameters:
- BITS, 8, message width (two's complement); MAX = 2**(BITS-1)-1
- dmax, 10, maximum row degree (edges per check node)
- INPUTS_BITS, $clog2(dmax), edge index width
- OFFSET, 1, offset-min-sum subtraction constant (unsigned, < MAX)
- DEPTH, 2, record FIFO depth

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  compressed record present
- in_ready  out  1  FIFO can accept a record
- min1  in  BITS  smallest magnitude in the row (signed, 0..MAX)
- min2  in  BITS  second-smallest magnitude (signed, 0..MAX)
- idx_min  in  INPUTS_BITS  edge index of min1
- sign_bits  in  dmax  per-edge input sign, 1 = negative, bit j is edge j
- deg  in  INPUTS_BITS+1  row degree, valid range 1..dmax
- out_valid  out  1  out_msg valid
- out_ready  in  1  downstream accepts out_msg
- out_msg  out  BITS  signed check-to-variable message
- out_edge  out  INPUTS_BITS  edge index of out_msg
- out_last  out  1  out_msg is the final edge of its record

Behaviour:
- Reset (async, immediate):
  - FIFO is empty, state is IDLE, edge counter is 0.
  - out_valid=0, out_msg=0, out_edge=0, out_last=0, in_ready=1.
- Input handshake:
  - A record is pushed on a clk edge where in_valid && in_ready.
  - in_ready = (count < DEPTH), driven from registered count only.
  - No push while full, even if a pop occurs in the same cycle.
- deg handling: a deg of 0 or greater than dmax is stored as dmax.
- State IDLE:
  - out_valid=0.
  - If the FIFO is non-empty, pop the head into the working registers, set edge=0, and go to EMIT.
- State EMIT: out_valid=1. On a cycle with out_ready=1:
  - If edge == deg-1 and the FIFO is non-empty: pop the next record and set edge=0. Back-to-back, no bubble.
  - If edge == deg-1 and the FIFO is empty: go to IDLE.
  - Otherwise: edge++.
- Backpressure: while out_valid && !out_ready, out_msg, out_edge and out_last hold stable.
- Latency:
  - A record pushed into an empty FIFO while in IDLE produces out_valid on the second clk edge after acceptance. It is popped on the first edge, and outputs are valid after the second.
  - No combinational path from any input to out_*. out_* are functions of registered state only.
- Arithmetic, per edge j of the working record:
  - tsign = XOR of sign_bits[0..deg-1]. Bits at or above deg are ignored.
  - sgn = tsign ^ sign_bits[j].
  - mag = (j == idx_min) ? min2 : min1. If idx_min >= deg, all edges use min1.
  - magc = mag - OFFSET, clipped to 0 when negative, then clipped to MAX.
  - out_msg = sgn ? -magc : magc. A magnitude of 0 gives 0 regardless of sgn.
- out_edge = edge counter; out_last = (edge == deg-1).
- Simultaneous events:
  - A push and a pop may occur in the same cycle; count is then unchanged.
  - A push into an empty FIFO in the same cycle as a last-edge handshake does not bypass: the state goes to IDLE, and the record is popped on the next cycle.
- Reset mid-operation: the current record and all FIFO contents are discarded, and out_valid falls immediately.

Test Plan:
- Assert rst asynchronously between edges -> out_valid, out_msg, out_edge and out_last go to 0 at once; in_ready=1.
- Single record, out_ready=1: deg=4, min1=5, min2=9, idx_min=2, sign_bits=...0011 (tsign=0) -> four consecutive beats, first valid on the second edge after accept:
  - edge0: -4
  - edge1: -4
  - edge2: +8
  - edge3: +4, out_last=1
  - then out_valid=0.
- Offset clipping: deg=3, min1=0, min2=1, idx_min=0, sign_bits=...111 -> all three messages are 0 (no negative zero); out_last on edge2.
- Out-of-range idx: deg=3, idx_min=5, min1=7, min2=20 -> all three messages have magnitude 6. Also deg=0 -> dmax=10 beats.
- Backpressure and full:
  - Hold out_ready=0 with 3 records offered -> one record in EMIT plus 2 in the FIFO, and in_ready=0 until the first pop.
  - out_msg stays stable across the stall cycles.
  - Releasing out_ready drains all messages in order with no lost or duplicated beats.
- Back-to-back: two deg=2 records queued, out_ready=1 -> 4 contiguous valid beats with out_last on beats 2 and 4. Then assert rst during beat 3 -> out_valid=0 immediately and nothing is emitted after reset release.
